// File: rtl/alu_dmem_if.sv
// Operand/control bundle between an issuing stage and the ALU + data-memory unit.
interface alu_dmem_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store_data;
    logic [31:0] mem_addr;
    logic [31:0] result;
    logic [31:0] difference;
    logic        rw;
    logic [31:0] mem_out;

    modport master (
        output opcode, funct, shamt, in1, in2, store_data, mem_addr,
        input  result, difference, rw, mem_out
    );

    modport slave (
        input  opcode, funct, shamt, in1, in2, store_data, mem_addr,
        output result, difference, rw, mem_out
    );
endinterface

// File: rtl/alu_dmem_unit.sv
// Combinational MIPS-subset ALU with a word-addressed data memory:
// asynchronous read, write on SW at the clock edge, synchronous clear on reset.
module alu_dmem_unit #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    alu_dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SLL = 6'b000000;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   sum, diff, alu_res;
    logic          rw_raw, wr_en;
    logic          unused_addr_bits;

    // Only the word index is decoded; byte offset and upper bits wrap.
    assign idx              = bus.mem_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};

    always_comb begin
        sum     = bus.in1 + bus.in2;
        diff    = bus.in1 - bus.in2;
        alu_res = '0;
        rw_raw  = 1'b0;
        wr_en   = 1'b0;
        case (bus.opcode)
            OP_R: begin
                rw_raw = 1'b1;
                case (bus.funct)
                    F_ADD:   alu_res = sum;
                    F_SUB:   alu_res = diff;
                    F_AND:   alu_res = bus.in1 & bus.in2;
                    F_OR:    alu_res = bus.in1 | bus.in2;
                    F_SRL:   alu_res = bus.in2 >> bus.shamt;
                    F_SLL:   alu_res = bus.in2 << bus.shamt;
                    default: rw_raw  = 1'b0;
                endcase
            end
            OP_LW: begin
                alu_res = sum;
                rw_raw  = 1'b1;
            end
            OP_SW: begin
                alu_res = sum;
                wr_en   = 1'b1;
            end
            OP_BEQ, OP_BNE: alu_res = diff;
            default: ;
        endcase
    end

    assign bus.result     = alu_res;
    assign bus.difference = diff;
    assign bus.rw         = rw_raw & ~reset;
    assign bus.mem_out    = mem_q[idx];

    // Reset takes priority, so a SW presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= bus.store_data;
        end
    end
endmodule

// File: tb/tb_alu_dmem_unit.sv
// Directed bench: a spec-level model checked every cycle, plus literal pins.
module tb_alu_dmem_unit;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_on = 1'b0;

    alu_dmem_if bus ();

    alu_dmem_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [31:0] mdl_mem [DEPTH];

    function automatic logic [31:0] m_result(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [4:0] sh, input logic [31:0] a,
                                             input logic [31:0] b);
        if (op == 6'h00) begin
            if (fn == 6'h20) return a + b;
            if (fn == 6'h22) return a - b;
            if (fn == 6'h24) return a & b;
            if (fn == 6'h25) return a | b;
            if (fn == 6'h02) return b >> sh;
            if (fn == 6'h00) return b << sh;
            return 32'h0;
        end
        if (op == 6'h23 || op == 6'h2B) return a + b;
        if (op == 6'h04 || op == 6'h05) return a - b;
        return 32'h0;
    endfunction

    function automatic logic m_rw(input logic [5:0] op, input logic [5:0] fn, input logic rst);
        if (rst) return 1'b0;
        if (op == 6'h23) return 1'b1;
        return op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h02, 6'h00});
    endfunction

    function automatic int m_index(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] <= 32'h0;
        end else if (bus.opcode == 6'h2B) begin
            mdl_mem[m_index(bus.mem_addr)] <= bus.store_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_result", bus.result,
                m_result(bus.opcode, bus.funct, bus.shamt, bus.in1, bus.in2));
            chk("cmp_difference", bus.difference, bus.in1 - bus.in2);
            chk("cmp_rw", {31'h0, bus.rw}, {31'h0, m_rw(bus.opcode, bus.funct, reset)});
            chk("cmp_mem_out", bus.mem_out, mdl_mem[m_index(bus.mem_addr)]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [31:0] addr);
        bus.opcode     = op;
        bus.funct      = fn;
        bus.shamt      = sh;
        bus.in1        = a;
        bus.in2        = b;
        bus.store_data = sd;
        bus.mem_addr   = addr;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(6'h00, 6'h20, 5'd0, 32'd1, 32'd2, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        cmp_on = 1'b1;

        // R-type add/sub
        drive(6'h00, 6'h20, 5'd0, 32'd7, 32'd5, 32'h0, 32'h0);
        chk("add_result", bus.result, 32'd12);
        chk("add_rw", {31'h0, bus.rw}, 32'd1);
        chk("rst_mem0", bus.mem_out, 32'h0);
        step();
        drive(6'h00, 6'h22, 5'd0, 32'd7, 32'd5, 32'h0, 32'h0);
        chk("sub_result", bus.result, 32'd2);
        chk("sub_diff", bus.difference, 32'd2);
        step();

        // logic and shifts
        drive(6'h00, 6'h24, 5'd0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h0);
        chk("and_result", bus.result, 32'h00F0);
        step();
        drive(6'h00, 6'h25, 5'd0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h0);
        chk("or_result", bus.result, 32'hFFF0);
        step();
        drive(6'h00, 6'h00, 5'd4, 32'h0, 32'd1, 32'h0, 32'h0);
        chk("sll_result", bus.result, 32'd16);
        step();
        drive(6'h00, 6'h02, 5'd31, 32'h0, 32'h80000000, 32'h0, 32'h0);
        chk("srl_result", bus.result, 32'd1);
        step();

        // modulo arithmetic
        drive(6'h00, 6'h20, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        chk("add_wrap", bus.result, 32'h0);
        step();
        drive(6'h00, 6'h22, 5'd0, 32'd0, 32'd1, 32'h0, 32'h0);
        chk("sub_wrap", bus.result, 32'hFFFFFFFF);
        step();

        // store then load; old value visible before the edge
        drive(6'h2B, 6'h00, 5'd0, 32'd8, 32'd4, 32'hDEADBEEF, 32'd12);
        chk("sw_old_value", bus.mem_out, 32'h0);
        chk("sw_rw", {31'h0, bus.rw}, 32'd0);
        chk("sw_result", bus.result, 32'd12);
        step();
        drive(6'h23, 6'h00, 5'd0, 32'd8, 32'd4, 32'h0, 32'd12);
        chk("lw_mem_out", bus.mem_out, 32'hDEADBEEF);
        chk("lw_result", bus.result, 32'd12);
        chk("lw_rw", {31'h0, bus.rw}, 32'd1);
        step();

        // back-to-back SW to the same word keeps the last
        drive(6'h2B, 6'h00, 5'd0, 32'd0, 32'd0, 32'h11111111, 32'd20);
        step();
        drive(6'h2B, 6'h00, 5'd0, 32'd0, 32'd0, 32'h22222222, 32'd21);
        chk("sw2_old_value", bus.mem_out, 32'h11111111);
        step();
        drive(6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 32'h0, 32'd20);
        chk("sw_last_wins", bus.mem_out, 32'h22222222);
        step();

        // branches
        drive(6'h04, 6'h00, 5'd0, 32'd9, 32'd9, 32'h0, 32'h0);
        chk("beq_result", bus.result, 32'd0);
        chk("beq_rw", {31'h0, bus.rw}, 32'd0);
        step();
        drive(6'h05, 6'h00, 5'd0, 32'd3, 32'd5, 32'h0, 32'h0);
        chk("bne_diff", bus.difference, 32'hFFFFFFFE);
        chk("bne_rw", {31'h0, bus.rw}, 32'd0);
        step();

        // address wrap
        drive(6'h2B, 6'h00, 5'd0, 32'd0, 32'd0, 32'hCAFEF00D, 32'h100);
        step();
        drive(6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0);
        chk("wrap_read", bus.mem_out, 32'hCAFEF00D);
        step();

        // unsupported opcode / funct
        drive(6'h3F, 6'h20, 5'd0, 32'd7, 32'd5, 32'h55AA55AA, 32'd4);
        chk("badop_result", bus.result, 32'h0);
        chk("badop_rw", {31'h0, bus.rw}, 32'd0);
        step();
        drive(6'h00, 6'h3F, 5'd0, 32'd7, 32'd5, 32'h0, 32'd4);
        chk("badop_no_write", bus.mem_out, 32'h0);
        chk("badfn_result", bus.result, 32'h0);
        chk("badfn_rw", {31'h0, bus.rw}, 32'd0);
        step();

        // reset with a pending SW: memory cleared, write dropped, rw low
        reset = 1'b1;
        drive(6'h2B, 6'h00, 5'd0, 32'd7, 32'd5, 32'h12345678, 32'd12);
        chk("rst_rw_sw", {31'h0, bus.rw}, 32'd0);
        chk("rst_result_live", bus.result, 32'd12);
        step();
        drive(6'h23, 6'h00, 5'd0, 32'd7, 32'd5, 32'h0, 32'd12);
        chk("rst_rw_lw", {31'h0, bus.rw}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 32'h0, 32'(i * 4));
            chk("post_rst_zero", bus.mem_out, 32'h0);
            step();
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_dmem_unit.md
ALU_DMEM_UNIT -- requirements
Module: alu_dmem_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port opcode, input, 6 bits: instruction opcode field.
REQ-004 The block SHALL have the port funct, input, 6 bits: R-type function field.
REQ-005 The block SHALL have the port shamt, input, 5 bits: shift amount.
REQ-006 The block SHALL have the port in1, input, 32 bits: operand A (Rs value).
REQ-007 The block SHALL have the port in2, input, 32 bits: operand B (Rt value or sign-extended offset).
REQ-008 The block SHALL have the port store_data, input, 32 bits: data written to memory on SW.
REQ-009 The block SHALL have the port mem_addr, input, 32 bits: byte address for memory access.
REQ-010 The block SHALL have the port result, output, 32 bits: ALU result.
REQ-011 The block SHALL have the port difference, output, 32 bits: in1 minus in2, provided for branch decisions.
REQ-012 The block SHALL have the port rw, output, 1 bit: register-file write enable for the current instruction.
REQ-013 The block SHALL have the port mem_out, output, 32 bits: memory read data.
REQ-014 The block SHALL have the parameter DEPTH, default 64: number of 32-bit data-memory words (power of 2).

Function
REQ-015 result, difference, rw and mem_out SHALL be combinational, with zero-cycle latency from their inputs.
REQ-016 When opcode is 000000, result SHALL be selected by funct:
- 100000: in1+in2
- 100010: in1-in2
- 100100: in1 AND in2
- 100101: in1 OR in2
- 000010: in2 logical-shifted right by shamt
- 000000: in2 logical-shifted left by shamt
REQ-017 All ALU arithmetic SHALL be 32-bit modulo 2^32 with no overflow flag or trap, e.g. 0xFFFFFFFF+1 gives 0 and 0-1 gives 0xFFFFFFFF.
REQ-018 When opcode is 100011 (LW) or 101011 (SW), result SHALL be in1+in2, the effective address.
REQ-019 When opcode is 000100 (BEQ) or 000101 (BNE), result SHALL be in1-in2.
REQ-020 difference SHALL equal in1-in2 for every opcode.
REQ-021 rw SHALL be 1 for the six supported R-type functs and for LW, and 0 for SW, BEQ, BNE, any unsupported funct, and any unsupported opcode.
REQ-022 An unsupported opcode or funct SHALL give result 0.
REQ-023 The memory word index SHALL be mem_addr[log2(DEPTH)+1:2].
- Address bits [1:0] SHALL be ignored (word-aligned access only).
- Higher address bits SHALL be ignored, so out-of-range addresses wrap.
REQ-024 mem_out SHALL read the word at the current index asynchronously, for every opcode.
REQ-025 When opcode is 101011 and reset is 0, the word at the index SHALL be written with store_data on the rising edge of clk; no other opcode SHALL write memory.
REQ-026 A read of the word being written in the same cycle SHALL return the old value until the clock edge, and the new value after it.
REQ-027 Consecutive SW operations to the same index on successive edges SHALL leave the last value written.

Reset
REQ-028 While reset is 1 at a rising clk edge, every memory word SHALL be cleared to 0, and any SW in that cycle SHALL be suppressed.
REQ-029 While reset is 1, rw SHALL be forced to 0; result and difference SHALL stay combinational.
REQ-030 After reset is released, mem_out SHALL read 0 at every address until a write occurs.
REQ-031 Asserting reset between a SW setup and its clock edge SHALL discard the write.

Verification
REQ-032 The bench SHALL check R-type: opcode 0, funct 100000, in1=7, in2=5 -> result=12, rw=1; funct 100010 -> result=2, difference=2.
REQ-033 The bench SHALL check logic and shifts: in1=0xF0F0, in2=0x0FF0, AND -> 0x00F0, OR -> 0xFFF0; in2=1, shamt=4, SLL -> 16; in2=0x80000000, SRL with shamt=31 -> 1.
REQ-034 The bench SHALL check store then load: SW with in1=8, in2=4, mem_addr=12, store_data=0xDEADBEEF, one edge; then LW at mem_addr=12 -> mem_out=0xDEADBEEF, result=12, rw=1.
REQ-035 The bench SHALL check branches: BEQ with in1=in2=9 -> result=0, rw=0; BNE with in1=3, in2=5 -> difference=0xFFFFFFFE, rw=0.
REQ-036 The bench SHALL check reset: after writes, reset=1 for one edge -> mem_out=0 at every address, rw=0 during reset; a SW issued with reset=1 -> memory stays 0.
REQ-037 The bench SHALL check wrap and unsupported codes: with DEPTH=64, SW to mem_addr=0x100 -> read at mem_addr=0 returns that data; opcode 111111 -> result=0, rw=0, no memory write.
